// File: rtl/ingress_throttle.sv
// Ingress throttle: a skid FIFO whose output side is gated by a pause/resume handshake.
// Buffering continues while paused; the downstream offer is held back until resume.
module ingress_throttle #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ACK_DELAY  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              pause_req,
    output logic              pause_ack,
    input  logic              resume_req,
    output logic              resume_ack,
    output logic              paused,
    output logic [6:0]        fifo_count,
    output logic [15:0]       pause_cycles
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        PAUSED = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        dly_q, dly_d;
    logic [15:0]       pcyc_q, pcyc_d;
    logic              pause_ack_q, pause_ack_d;
    logic              resume_ack_q, resume_ack_d;
    logic              paused_q, paused_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [6:0]        count_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push_s, pop_s, stalled_s;

    // Handshake qualifiers; rst_n gates in_ready so nothing is accepted during reset
    assign in_ready  = rst_n && enable && (count_q < 7'(FIFO_DEPTH));
    assign out_valid = enable && (count_q != 7'd0) && ((state_q == RUN) || (state_q == RESUME));
    assign out_data  = mem_q[rd_ptr_q];
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign stalled_s = out_valid && !out_ready;

    assign pause_ack    = pause_ack_q;
    assign resume_ack   = resume_ack_q;
    assign paused       = paused_q;
    assign fifo_count   = count_q;
    assign pause_cycles = pcyc_q;

    // State register, delay counter, pause statistics and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            dly_q        <= 4'd0;
            pcyc_q       <= 16'd0;
            pause_ack_q  <= 1'b0;
            resume_ack_q <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            pcyc_q       <= pcyc_d;
            pause_ack_q  <= pause_ack_d;
            resume_ack_q <= resume_ack_d;
            paused_q     <= paused_d;
        end
    end

    // Next-state logic; a stalled offer must complete before leaving RUN
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        pcyc_d  = pcyc_q;
        if (enable) begin
            case (state_q)
                RUN: begin
                    if (pause_req && !stalled_s) begin
                        state_d = HOLD;
                        dly_d   = 4'(ACK_DELAY);
                    end else begin
                        state_d = RUN;
                    end
                end
                HOLD: begin
                    if (dly_q == 4'd0) begin
                        state_d = PAUSED;
                    end else begin
                        dly_d = dly_q - 4'd1;
                    end
                end
                PAUSED: begin
                    if (pcyc_q != 16'hFFFF) begin
                        pcyc_d = pcyc_q + 16'd1;
                    end else begin
                        pcyc_d = pcyc_q;
                    end
                    if (resume_req) begin
                        state_d = RESUME;
                    end else begin
                        state_d = PAUSED;
                    end
                end
                RESUME:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode, computed one cycle ahead so the outputs leave a flop
    always_comb begin
        paused_d = (state_d == HOLD) || (state_d == PAUSED);
        if (enable) begin
            pause_ack_d  = (state_d == HOLD) && (dly_d == 4'd0);
            resume_ack_d = (state_d == RESUME) && (state_q == PAUSED);
        end else begin
            pause_ack_d  = 1'b0;
            resume_ack_d = 1'b0;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 7'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 7'd1;
                2'b01:   count_q <= count_q - 7'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; reset only needs to clear the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_ingress_throttle.sv
// Directed bench for ingress_throttle: a vector table for FIFO and pause/resume
// timing, plus hand-written sequences for stall, freeze, reset and saturation.
module tb_ingress_throttle;

    logic        clk, rst_n, enable, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        pause_req, pause_ack, resume_req, resume_ack, paused;
    logic [6:0]  fifo_count;
    logic [15:0] pause_cycles;
    int          checks, errors;

    ingress_throttle dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .resume_req(resume_req), .resume_ack(resume_ack),
        .paused(paused), .fifo_count(fifo_count), .pause_cycles(pause_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, iv;
        logic [31:0] d;
        logic        ordy, preq, rreq;
        logic        x_ir, x_ov;
        logic [31:0] x_od;
        logic        x_pack, x_rack, x_paused;
        logic [6:0]  x_cnt;
        logic [15:0] x_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic preq, input logic rreq,
                                input logic ir, input logic ov, input logic [31:0] od,
                                input logic pack, input logic rack, input logic pz,
                                input logic [6:0] cnt, input logic [15:0] pc);
        vec_t v;
        v.en = en; v.iv = iv; v.d = d; v.ordy = ordy; v.preq = preq; v.rreq = rreq;
        v.x_ir = ir; v.x_ov = ov; v.x_od = od; v.x_pack = pack; v.x_rack = rack;
        v.x_paused = pz; v.x_cnt = cnt; v.x_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic iv, input logic [31:0] d,
                          input logic ordy, input logic preq, input logic rreq);
        enable = en; in_valid = iv; in_data = d; out_ready = ordy;
        pause_req = preq; resume_req = rreq;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_pcyc"}, 32'(pause_cycles), 32'd0);
        chk({tag, "_paused"}, 32'(paused), 32'd0);
        chk({tag, "_pack"}, 32'(pause_ack), 32'd0);
        chk({tag, "_rack"}, 32'(resume_ack), 32'd0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_reset_vals("rst");
        step;
        step;
        rst_n = 1'b1;
    endtask

    // Raise pause_req with the FIFO empty and walk through HOLD to PAUSED
    task automatic enter_paused;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step;
        repeat (3) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            step;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        enable = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        pause_req = 1'b0; resume_req = 1'b0;
        step;
        do_reset;

        // Fill to full with the output blocked
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 1'b1, 32'hA000_0000 + k, 1'b0, 1'b0, 1'b0,
                             1'b1, (k > 0), 32'hA000_0000, 1'b0, 1'b0, 1'b0, 7'(k), 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'hA000_0008, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 7'd8, 16'd0));
        // Drain in order; a push offered while full must be refused, resume_req ignored in RUN
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(1'b1, (j == 0), 32'hDEAD_BEEF, 1'b1, 1'b0, (j == 3),
                             (j > 0), 1'b1, 32'hA000_0000 + j, 1'b0, 1'b0, 1'b0, 7'(8 - j), 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'hB000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 1'b0, 7'd1, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0, 7'd1, 16'd0));
        // Pause at T with FIFO empty: paused from T+1, ack at T+3
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd0, 16'd1));
        tbl.push_back(mk(1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd1, 16'd2));
        // Both requests in PAUSED: resume wins, no pause_ack
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7'd2, 16'd3));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC000_0000, 1'b0, 1'b1, 1'b0, 7'd2, 16'd4));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC000_0001, 1'b0, 1'b0, 1'b0, 7'd1, 16'd4));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd4));

        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].preq, tbl[i].rreq);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].x_ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].x_ov));
            if (tbl[i].x_ov)
                chk($sformatf("v%0d_out_data", i), out_data, tbl[i].x_od);
            chk($sformatf("v%0d_pause_ack", i), 32'(pause_ack), 32'(tbl[i].x_pack));
            chk($sformatf("v%0d_resume_ack", i), 32'(resume_ack), 32'(tbl[i].x_rack));
            chk($sformatf("v%0d_paused", i), 32'(paused), 32'(tbl[i].x_paused));
            chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tbl[i].x_cnt));
            chk($sformatf("v%0d_pcyc", i), 32'(pause_cycles), 32'(tbl[i].x_pc));
            step;
        end

        // Pause during a stalled offer: offer held, HOLD only after the pop
        do_reset;
        set_in(1'b1, 1'b1, 32'hD000_0000, 1'b0, 1'b0, 1'b0); step;
        set_in(1'b1, 1'b1, 32'hD000_0001, 1'b0, 1'b0, 1'b0); step;
        for (int c = 0; c < 5; c++) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            chk("stall_ov", 32'(out_valid), 32'd1);
            chk("stall_od", out_data, 32'hD000_0000);
            chk("stall_paused", 32'(paused), 32'd0);
            step;
        end
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("stall_pop_od", out_data, 32'hD000_0000);
        step;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_paused", 32'(paused), 32'd1);
        chk("stall_hold_ov", 32'(out_valid), 32'd0);
        chk("stall_hold_cnt", 32'(fifo_count), 32'd1);
        step;
        chk("stall_ack_early", 32'(pause_ack), 32'd0);
        step;
        chk("stall_ack", 32'(pause_ack), 32'd1);
        step;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_ack_pulse", 32'(pause_ack), 32'd0);
        step;
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("stall_rack", 32'(resume_ack), 32'd1);
        chk("stall_next_od", out_data, 32'hD000_0001);
        step;
        chk("stall_empty", 32'(fifo_count), 32'd0);

        // Resume after 10 PAUSED cycles with 3 words buffered
        do_reset;
        enter_paused;
        for (int c = 0; c < 10; c++) begin
            set_in(1'b1, (c < 3), 32'hE000_0000 + c, 1'b0, 1'b0, (c == 9));
            chk("res_ov", 32'(out_valid), 32'd0);
            chk("res_pcyc", 32'(pause_cycles), 32'(c));
            step;
        end
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("res_rack", 32'(resume_ack), 32'd1);
        chk("res_pcyc10", 32'(pause_cycles), 32'd10);
        chk("res_cnt3", 32'(fifo_count), 32'd3);
        for (int c = 0; c < 3; c++) begin
            chk("res_drain_ov", 32'(out_valid), 32'd1);
            chk("res_drain_od", out_data, 32'hE000_0000 + c);
            step;
            if (c == 0) chk("res_rack_pulse", 32'(resume_ack), 32'd0);
        end
        chk("res_drained", 32'(fifo_count), 32'd0);

        // enable=0 in HOLD freezes the delay counter and blocks both FIFO ports
        do_reset;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0); step;
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, 1'b1, 32'hF000_0000, 1'b1, 1'b0, 1'b0);
            chk("frz_ir", 32'(in_ready), 32'd0);
            chk("frz_ack", 32'(pause_ack), 32'd0);
            chk("frz_paused", 32'(paused), 32'd1);
            step;
        end
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            chk("frz_ack_after", 32'(pause_ack), 32'((c == 2) ? 1 : 0));
            chk("frz_cnt", 32'(fifo_count), 32'd0);
            step;
        end

        // Reset mid-HOLD drops the pending acknowledge
        do_reset;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0); step;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0); step;
        do_reset;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            chk("rsth_ack", 32'(pause_ack), 32'd0);
            chk("rsth_paused", 32'(paused), 32'd0);
            step;
        end

        // Reset mid-PAUSED with 4 words buffered
        do_reset;
        enter_paused;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 1'b1, 32'h1000_0000 + c, 1'b0, 1'b0, 1'b0);
            step;
        end
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rstp_cnt4", 32'(fifo_count), 32'd4);
        chk("rstp_paused", 32'(paused), 32'd1);
        do_reset;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
            chk("rstp_pack", 32'(pause_ack), 32'd0);
            chk("rstp_rack", 32'(resume_ack), 32'd0);
            chk("rstp_cnt", 32'(fifo_count), 32'd0);
            chk("rstp_ov", 32'(out_valid), 32'd0);
            step;
        end

        // pause_cycles saturates at 16'hFFFF
        do_reset;
        enter_paused;
        set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (65540) step;
        chk("sat_pcyc", 32'(pause_cycles), 32'h0000_FFFF);
        chk("sat_paused", 32'(paused), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
